// File: rtl/qam_pkg.sv
// Shared types and constants for the 16-QAM transmit path.
package qam_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} qam_state_e;

  localparam int LEVEL_W = 3;

  localparam logic signed [LEVEL_W-1:0] LVL_M3 = -3'sd3;
  localparam logic signed [LEVEL_W-1:0] LVL_M1 = -3'sd1;
  localparam logic signed [LEVEL_W-1:0] LVL_P1 = 3'sd1;
  localparam logic signed [LEVEL_W-1:0] LVL_P3 = 3'sd3;

  // Gray coding: adjacent amplitude levels differ by one bit
  localparam logic [1:0] GRAY_M3 = 2'b00;
  localparam logic [1:0] GRAY_M1 = 2'b01;
  localparam logic [1:0] GRAY_P1 = 2'b11;
  localparam logic [1:0] GRAY_P3 = 2'b10;

endpackage

// File: rtl/qam_level_map.sv
// Gray-coded 2-bit symbol field to signed amplitude level.
module qam_level_map
  import qam_pkg::*;
(
  input  logic        [1:0]         code,
  output logic signed [LEVEL_W-1:0] level
);

  always_comb begin
    level = LVL_P3;
    case (code)
      GRAY_M3: level = LVL_M3;
      GRAY_M1: level = LVL_M1;
      GRAY_P1: level = LVL_P1;
      default: level = LVL_P3;
    endcase
  end

endmodule

// File: rtl/qam_symbol_mixer.sv
// Symbol buffer/timer plus 3-stage I*cos + Q*sin mixer producing an offset-binary DAC sample.
module qam_symbol_mixer
  import qam_pkg::*;
#(
  parameter int SYMBOL_LEN    = 230,
  parameter int CARRIER_WIDTH = 32,
  parameter int OUT_WIDTH     = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CARRIER_WIDTH-1:0] carrier_i,
  input  logic [CARRIER_WIDTH-1:0] carrier_q,
  input  logic                     enable,
  input  logic [3:0]               sym_data,
  input  logic                     sym_valid,
  output logic                     sym_ready,
  output logic                     sym_strobe,
  output logic                     underrun,
  output logic [OUT_WIDTH-1:0]     mod_out,
  output logic                     mod_valid
);

  localparam int CNT_W  = $clog2(SYMBOL_LEN);
  localparam int PROD_W = CARRIER_WIDTH + LEVEL_W;
  localparam int SUM_W  = PROD_W + 1;
  localparam int SHIFT  = SUM_W - OUT_WIDTH;
  localparam int STAGES = 3;
  localparam logic [OUT_WIDTH-1:0] MIDSCALE = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  qam_state_e state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       pending, current;
  logic             pending_full, load, sym_end, end_underrun, transfer;

  assign sym_end   = (state == RUN) && (cnt == CNT_W'(SYMBOL_LEN - 1));
  assign sym_ready = !rst && (!pending_full || load);
  assign transfer  = sym_valid && sym_ready;

  always_comb begin
    state_nxt    = state;
    load         = 1'b0;
    end_underrun = 1'b0;
    case (state)
      IDLE: if (pending_full && enable) begin
        load      = 1'b1;
        state_nxt = RUN;
      end
      RUN: if (sym_end) begin
        // enable only matters at the boundary, so a symbol is never cut short
        if (!enable)           state_nxt = IDLE;
        else if (pending_full) load      = 1'b1;
        else begin
          end_underrun = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      current      <= '0;
      sym_strobe   <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      state      <= state_nxt;
      sym_strobe <= load;
      underrun   <= end_underrun;
      if (load || sym_end)    cnt <= '0;
      else if (state == RUN)  cnt <= cnt + 1'b1;
      if (load) current <= pending;
      // a refill on the load edge keeps the stream gapless
      if (transfer) begin
        pending      <= sym_data;
        pending_full <= 1'b1;
      end else if (load) begin
        pending_full <= 1'b0;
      end
    end
  end

  // lane 1 = I from [3:2], lane 0 = Q from [1:0]
  logic [1:0][1:0]         codes;
  logic [1:0][LEVEL_W-1:0] lvl_raw;
  logic signed [LEVEL_W-1:0] lvl_i, lvl_q;

  assign codes = {current[3:2], current[1:0]};

  qam_level_map u_map [1:0] (
    .code  (codes),
    .level (lvl_raw)
  );

  assign lvl_i = (state == RUN) ? $signed(lvl_raw[1]) : '0;
  assign lvl_q = (state == RUN) ? $signed(lvl_raw[0]) : '0;

  logic signed [PROD_W-1:0] prod_i, prod_q;
  logic signed [SUM_W-1:0]  sum;
  logic [STAGES:0]          vld_pipe;
  logic                     sum_frac_unused;

  assign vld_pipe[0]     = (state == RUN);
  assign mod_valid       = vld_pipe[STAGES];
  assign sum_frac_unused = ^sum[SHIFT-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_i             <= '0;
      prod_q             <= '0;
      sum                <= '0;
      mod_out            <= MIDSCALE;
      vld_pipe[STAGES:1] <= '0;
    end else begin
      prod_i             <= PROD_W'(lvl_i) * PROD_W'($signed(carrier_i));
      prod_q             <= PROD_W'(lvl_q) * PROD_W'($signed(carrier_q));
      sum                <= SUM_W'(prod_i) + SUM_W'(prod_q);
      // arithmetic shift then truncate == top OUT_WIDTH bits; MSB flip gives offset binary
      mod_out            <= {~sum[SUM_W-1], sum[SUM_W-2:SHIFT]};
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end
  end

endmodule

// File: tb/tb_qam_symbol_mixer.sv
// Self-checking bench for qam_symbol_mixer: vector table, hand sequences and random streams.
module tb_qam_symbol_mixer;

  localparam int SL = 4;

  typedef logic [3:0]  sym_q_t[$];
  typedef logic [11:0] out_q_t[$];

  typedef struct {
    logic [3:0]  sym;
    logic [31:0] ci;
    logic [31:0] cq;
    logic [11:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] carrier_i, carrier_q;
  logic        enable, sym_valid;
  logic [3:0]  sym_data;
  logic        sym_ready, sym_strobe, underrun, mod_valid;
  logic [11:0] mod_out;

  qam_symbol_mixer #(.SYMBOL_LEN(SL), .CARRIER_WIDTH(32), .OUT_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .carrier_i(carrier_i), .carrier_q(carrier_q),
    .enable(enable), .sym_data(sym_data), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .sym_strobe(sym_strobe), .underrun(underrun),
    .mod_out(mod_out), .mod_valid(mod_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: Gray level map and mixer math straight from the amplitude rules
  function automatic longint level_of(input logic [1:0] g);
    case (g)
      2'b00:   return -3;
      2'b01:   return -1;
      2'b11:   return 1;
      default: return 3;
    endcase
  endfunction

  function automatic logic [11:0] model(input logic [3:0] s, input logic [31:0] ci, input logic [31:0] cq);
    longint acc, sh;
    acc = level_of(s[3:2]) * longint'($signed(ci)) + level_of(s[1:0]) * longint'($signed(cq));
    sh  = acc >>> 24;
    return 12'(sh) ^ 12'h800;
  endfunction

  // Output monitor
  bit          mon_on = 1'b0;
  logic [11:0] got_q[$];
  int          un_cnt, st_cnt, idle_bad, first_cyc, last_cyc;
  int          cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (mon_on) begin
      if (mod_valid) begin
        if (got_q.size() == 0) first_cyc = cyc;
        last_cyc = cyc;
        got_q.push_back(mod_out);
      end else if (mod_out !== 12'h800) idle_bad++;
      if (underrun)   un_cnt++;
      if (sym_strobe) st_cnt++;
    end
  end

  task automatic mon_clear();
    got_q.delete();
    un_cnt = 0; st_cnt = 0; idle_bad = 0; first_cyc = 0; last_cyc = -1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [3:0] s);
    bit ok = 1'b0;
    bit r;
    sym_valid = 1'b1;
    sym_data  = s;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk); r = sym_ready;
      @(posedge clk); #1;
      if (r) ok = 1'b1;
    end
    sym_valid = 1'b0;
    if (!ok) chk("xfer_timeout", 0, 1);
  endtask

  task automatic wait_strobe(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (sym_strobe) seen = 1'b1;
    end
    chk(nm, seen, 1);
  endtask

  task automatic run_stream(input string nm, input sym_q_t syms, input out_q_t exp);
    int n;
    mon_clear();
    mon_on = 1'b1;
    foreach (syms[i]) send(syms[i]);
    tick(SL * syms.size() + 12);
    mon_on = 1'b0;
    chk({nm, "_count"}, got_q.size(), exp.size());
    n = (got_q.size() < exp.size()) ? got_q.size() : exp.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_out[%0d]", nm, i), got_q[i], exp[i]);
    chk({nm, "_contig"}, last_cyc - first_cyc + 1, got_q.size());
    chk({nm, "_underrun"}, un_cnt, 1);
    chk({nm, "_strobes"}, st_cnt, syms.size());
    chk({nm, "_idle_mid"}, idle_bad, 0);
  endtask

  vec_t   tbl[8];
  sym_q_t sq;
  out_q_t eq;

  initial begin
    tbl[0] = '{4'b1010, 32'h4000_0000, 32'h0,         12'h8C0};
    tbl[1] = '{4'b0000, 32'h4000_0000, 32'h0,         12'h740};
    tbl[2] = '{4'b0110, 32'h4000_0000, 32'h0,         12'h7C0};
    tbl[3] = '{4'b1111, 32'h4000_0000, 32'h0,         12'h840};
    tbl[4] = '{4'b0010, 32'h0,         32'hC000_0000, 12'h740};
    tbl[5] = '{4'b0101, 32'h4000_0000, 32'h4000_0000, 12'h780};
    tbl[6] = '{4'b1010, 32'h8000_0000, 32'h8000_0000, 12'h500};
    tbl[7] = '{4'b0000, 32'h8000_0000, 32'h8000_0000, 12'hB00};

    rst = 1'b1; enable = 1'b0; sym_valid = 1'b0; sym_data = '0;
    carrier_i = 32'h4000_0000; carrier_q = 32'h0;

    // Reset
    tick(5);
    chk("rst_mod_out", mod_out, 12'h800);
    chk("rst_mod_valid", mod_valid, 0);
    chk("rst_sym_ready", sym_ready, 0);
    chk("rst_strobe", sym_strobe, 0);
    chk("rst_underrun", underrun, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_sym_ready", sym_ready, 1);
    tick(1);
    enable = 1'b1;

    // Table of single symbols
    foreach (tbl[t]) begin
      carrier_i = tbl[t].ci;
      carrier_q = tbl[t].cq;
      sq.delete(); eq.delete();
      sq.push_back(tbl[t].sym);
      repeat (SL) eq.push_back(tbl[t].exp);
      run_stream($sformatf("tbl%0d", t), sq, eq);
    end

    // Back-to-back stream
    carrier_i = 32'h4000_0000; carrier_q = 32'h0;
    sq.delete(); eq.delete();
    sq.push_back(4'b0000); sq.push_back(4'b0110); sq.push_back(4'b1111);
    repeat (SL) eq.push_back(12'h740);
    repeat (SL) eq.push_back(12'h7C0);
    repeat (SL) eq.push_back(12'h840);
    run_stream("b2b", sq, eq);

    // Enable drop with a queued symbol
    mon_clear(); mon_on = 1'b1;
    send(4'b1010);
    send(4'b0000);
    wait_strobe("drop_strobe");
    tick(1);
    enable = 1'b0;
    tick(10);
    chk("drop_no_underrun", un_cnt, 0);
    chk("drop_ready_low", sym_ready, 0);
    chk("drop_idle_valid", mod_valid, 0);
    chk("drop_first_count", got_q.size(), SL);
    enable = 1'b1;
    tick(1);
    chk("drop_reload_strobe", sym_strobe, 1);
    tick(12);
    mon_on = 1'b0;
    chk("drop_total_count", got_q.size(), 2 * SL);
    if (got_q.size() == 2 * SL) begin
      chk("drop_first_val", got_q[0], 12'h8C0);
      chk("drop_first_last", got_q[SL-1], 12'h8C0);
      chk("drop_second_val", got_q[SL], 12'h740);
      chk("drop_second_last", got_q[2*SL-1], 12'h740);
    end
    chk("drop_end_underrun", un_cnt, 1);
    chk("drop_strobes", st_cnt, 2);

    // Reset mid-symbol
    mon_clear(); mon_on = 1'b1;
    send(4'b1010);
    send(4'b0000);
    wait_strobe("midrst_strobe");
    tick(2);
    rst = 1'b1;
    #1;
    chk("midrst_mod_out", mod_out, 12'h800);
    chk("midrst_mod_valid", mod_valid, 0);
    chk("midrst_ready", sym_ready, 0);
    tick(2);
    rst = 1'b0;
    mon_clear();
    tick(15);
    mon_on = 1'b0;
    chk("midrst_no_output", got_q.size(), 0);
    chk("midrst_no_strobe", st_cnt, 0);
    chk("midrst_no_underrun", un_cnt, 0);
    chk("midrst_ready_after", sym_ready, 1);

    // Random streams against the reference model
    for (int t = 0; t < 6; t++) begin
      int n;
      carrier_i = $urandom;
      carrier_q = $urandom;
      n = $urandom_range(1, 5);
      sq.delete(); eq.delete();
      for (int k = 0; k < n; k++) begin
        logic [3:0] s;
        s = 4'($urandom);
        sq.push_back(s);
        repeat (SL) eq.push_back(model(s, carrier_i, carrier_q));
      end
      run_stream($sformatf("rnd%0d", t), sq, eq);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/qam_symbol_mixer.md
# qam_symbol_mixer

Downstream stage of `carrier_gen` in the QAM transmit path. It accepts 16-QAM symbols over a valid/ready handshake and holds each symbol for a fixed number of clocks. Each symbol is mapped to signed I/Q amplitude levels, and the block computes `I·carrier_i + Q·carrier_q` in a three-stage pipeline. The result is an offset-binary DAC sample. The block runs on the same 230,401.25 Hz clock as the carrier generator.

## Interface
**Parameters**
- `SYMBOL_LEN`, 230: clocks per symbol (≥2).
- `CARRIER_WIDTH`, 32: width of the carrier inputs.
- `OUT_WIDTH`, 12: DAC sample width.

**Ports**
- `clk` in 1: sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `carrier_i` in CARRIER_WIDTH: in-phase carrier, two's complement.
- `carrier_q` in CARRIER_WIDTH: quadrature carrier, two's complement.
- `enable` in 1: permits starting or continuing modulation; sampled only at symbol boundaries.
- `sym_data` in 4: symbol; `[3:2]` selects the I level, `[1:0]` selects the Q level.
- `sym_valid` in 1: upstream offers `sym_data`.
- `sym_ready` out 1: the block can accept a symbol.
- `sym_strobe` out 1: one-clock pulse in the first cycle of each new symbol period.
- `underrun` out 1: one-clock pulse when a symbol period ends with no symbol queued.
- `mod_out` out OUT_WIDTH: offset-binary modulated sample.
- `mod_valid` out 1: `mod_out` carries a modulated (RUN) sample.

## Operation
**Buffering**
- The block has a one-entry `pending` register plus a `current` symbol register.
- `sym_ready = !rst && (!pending_full || load)`.
- A transfer happens on a clock edge where `sym_valid && sym_ready`.
- If a transfer and a load occur on the same edge, `pending` is refilled and no bubble is inserted.

**Level map (Gray coded)**
- 2'b00 → −3, 2'b01 → −1, 2'b11 → +1, 2'b10 → +3.
- In IDLE, both levels are forced to 0.

**FSM states**
- IDLE (reset state):
  - If `pending_full && enable`: load `pending` into `current`, set counter to 0, pulse `sym_strobe`, go to RUN.
- RUN:
  - The counter increments every clock.
  - At `SYMBOL_LEN-1` with `enable` high and `pending_full`: load, wrap the counter to 0, pulse `sym_strobe`, stay in RUN.
  - At `SYMBOL_LEN-1` with `enable` high and `!pending_full`: pulse `underrun`, go to IDLE.
  - At `SYMBOL_LEN-1` with `enable` low: go to IDLE with no underrun pulse. `pending` is retained.
  - Deasserting `enable` mid-symbol never truncates the symbol.

**Arithmetic**
- Products are 3-bit signed level × CARRIER_WIDTH-bit signed carrier, giving CARRIER_WIDTH+3 bits.
- The sum `s` is CARRIER_WIDTH+4 bits and cannot overflow.
- `mod_out = (s >>> (CARRIER_WIDTH+4−OUT_WIDTH))` with its MSB inverted (arithmetic shift, truncation, no rounding).
- Consequences: a zero sum gives midscale `2^(OUT_WIDTH−1)`, and IDLE outputs midscale.

## Timing
**Reset values**
- `mod_out` = `2^(OUT_WIDTH−1)` (0x800 at default width).
- `mod_valid`, `sym_strobe`, `underrun` = 0.
- `sym_ready` = 0 while `rst` is high, and 1 on the first cycle after release.
- Counter, `pending_full`, FSM state, pipeline registers all clear.

**Pipeline and latency**
- Stage 1 registers the two products, stage 2 registers the sum, stage 3 registers `mod_out`.
- The carrier sampled at edge n, with the levels current at edge n, appears on `mod_out` after edge n+2 (3-register latency).
- `mod_valid` is `(state==RUN)` delayed by the same three registers.
- The first sample of a symbol is therefore visible 3 cycles after `sym_strobe` rises.

**Start-up latency**
- With `enable` high in IDLE, a transfer at edge k sets `pending_full`. The load happens at edge k+1, so `sym_strobe` is high in the cycle after k+1.

**Reset mid-operation**
- An asserted `rst` immediately clears all state, including any queued symbol, which is lost.
- `mod_out` snaps to midscale asynchronously.

## Structure
**Shared package `qam_pkg`**
- FSM state enum `{IDLE, RUN}`.
- `LEVEL_W = 3`.
- Level constants `LVL_M3`, `LVL_M1`, `LVL_P1`, `LVL_P3`.
- Gray-code bit patterns.

**Sub-module `qam_level_map`**
- Combinational 2-bit Gray code → 3-bit signed level.
- Instantiated twice (I and Q).

**Top level**
- FSM, counter, buffers and pipeline all live in `qam_symbol_mixer`.

## Test plan
All scenarios use `SYMBOL_LEN=4`, default widths, `carrier_i=32'h4000_0000` and `carrier_q=0` unless stated.
- **Reset:** hold `rst` for 5 clocks → `mod_out=0x800`, `mod_valid=0`, `sym_ready=0`; after release, `sym_ready=1`.
- **Single symbol:** send 4'b1010 with `enable=1` → `sym_strobe` pulses once, then `mod_out=0x8C0` with `mod_valid=1` for exactly 4 cycles, then `underrun` pulses and `mod_out` returns to 0x800.
- **Back-to-back stream:** send 4'b0000, 4'b0110, 4'b1111 with `sym_valid` held high → outputs are 0x740 ×4, 0x7C0 ×4, 0x840 ×4, contiguous. There is no gap, `mod_valid` stays high, and `underrun` fires once, only at the end.
- **Quadrature:** set `carrier_i=0`, `carrier_q=32'hC000_0000`, send 4'b0010 (I=−3, Q=+3) → `mod_out=0x740`.
- **Enable drop:** deassert `enable` in cycle 1 of a symbol with a second symbol queued → the current symbol completes all 4 cycles, the FSM goes to IDLE with no `underrun`, and `sym_ready=0`. Reasserting `enable` loads the queued symbol on the next edge.
- **Reset mid-symbol:** assert `rst` in cycle 2 → `mod_out=0x800` immediately and `pending` clears. After release, nothing is output until a new transfer.
